// File: rtl/rr_priority_encoder.sv
// Registered N-to-log2(N) priority encoder with fixed-priority or round-robin
// selection, all-zero / multi-hot flags and a saturating malformed-input counter.
module rr_priority_encoder #(
    parameter int N     = 8,
    parameter int MODE  = 0,
    parameter int CNT_W = 8,
    localparam int W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_idx,
    output logic             out_none,
    output logic             out_multi,
    output logic [CNT_W-1:0] bad_cnt
);

    // Handshake: a side transfers when its valid and ready are both high on a
    // rising edge; the result register accepts a new vector whenever it is
    // empty or is being drained in the same cycle.
    logic             xfer_in;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     idx_q, idx_d;
    logic             none_q, none_d;
    logic             multi_q, multi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     ptr_q, ptr_d;

    logic [W-1:0]     sel_fp;
    logic [W-1:0]     sel_rr;
    logic             found_rr;
    logic [W-1:0]     sel;
    logic             is_none;
    logic             is_multi;

    assign in_ready = !out_valid_q || out_ready;
    assign xfer_in  = in_valid && in_ready;

    assign is_none  = ~|in;
    assign is_multi = |(in & (in - {{(N-1){1'b0}}, 1'b1}));

    // Lowest set index wins: scan downward so the last hit is the lowest.
    always_comb begin
        sel_fp = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) begin
                sel_fp = W'(i);
            end
        end
    end

    // Round-robin: first set bit at or after ptr, wrapping modulo N.
    always_comb begin
        int j;
        sel_rr   = '0;
        found_rr = 1'b0;
        j        = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found_rr && in[j]) begin
                found_rr = 1'b1;
                sel_rr   = W'(j);
            end
        end
    end

    assign sel = (MODE == 1) ? sel_rr : sel_fp;

    always_comb begin
        out_valid_d = xfer_in || (out_valid_q && !out_ready);
        idx_d       = idx_q;
        none_d      = none_q;
        multi_d     = multi_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        if (xfer_in) begin
            idx_d   = sel;
            none_d  = is_none;
            multi_d = is_multi;
            if ((is_none || is_multi) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if ((MODE == 1) && !is_none) begin
                ptr_d = (sel == W'(N - 1)) ? '0 : sel + {{(W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            none_q      <= 1'b0;
            multi_q     <= 1'b0;
            cnt_q       <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
            none_q      <= none_d;
            multi_q     <= multi_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = idx_q;
    assign out_none  = none_q;
    assign out_multi = multi_q;
    assign bad_cnt   = cnt_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder: three configurations (N=8 fixed,
// N=8 round-robin, N=5 round-robin with a 2-bit counter) share one clock.
module tb_rr_priority_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_bus;
    logic       out_ready;
    logic [2:0] in_valid_v;
    logic [2:0] in_ready_v;
    logic [2:0] out_valid_v;
    logic [2:0] none_v;
    logic [2:0] multi_v;
    logic [2:0] idx0, idx1, idx2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // packed expectation: {cnt[7:0], multi, none, idx[2:0]}
    logic [12:0] exp0_q[$];
    logic [12:0] exp1_q[$];
    logic [12:0] exp2_q[$];

    always #5 clk = ~clk;

    rr_priority_encoder #(.N(8), .MODE(0), .CNT_W(8)) u_fp8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in(in_bus),
        .in_ready(in_ready_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .out_idx(idx0), .out_none(none_v[0]), .out_multi(multi_v[0]), .bad_cnt(cnt0)
    );

    rr_priority_encoder #(.N(8), .MODE(1), .CNT_W(8)) u_rr8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in(in_bus),
        .in_ready(in_ready_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .out_idx(idx1), .out_none(none_v[1]), .out_multi(multi_v[1]), .bad_cnt(cnt1)
    );

    rr_priority_encoder #(.N(5), .MODE(1), .CNT_W(2)) u_rr5 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in(in_bus[4:0]),
        .in_ready(in_ready_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .out_idx(idx2), .out_none(none_v[2]), .out_multi(multi_v[2]), .bad_cnt(cnt2)
    );

    function automatic logic [12:0] pack(input logic [2:0] idx, input logic none,
                                         input logic multi, input logic [7:0] cnt);
        return {cnt, multi, none, idx};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_pop(input int inst, input logic [12:0] act);
        logic [12:0] e;
        logic        empty;
        empty = 1'b0;
        e     = '0;
        case (inst)
            0: if (exp0_q.size() == 0) empty = 1'b1; else e = exp0_q.pop_front();
            1: if (exp1_q.size() == 0) empty = 1'b1; else e = exp1_q.pop_front();
            default: if (exp2_q.size() == 0) empty = 1'b1; else e = exp2_q.pop_front();
        endcase
        n_checks++;
        if (empty) begin
            n_fail++;
            $display("FAIL result[%0d]: unexpected output idx=%0d none=%0b multi=%0b cnt=%0d, expected none queued",
                     inst, act[2:0], act[3], act[4], act[12:5]);
        end else if (act !== e) begin
            n_fail++;
            $display("FAIL result[%0d]: got idx=%0d none=%0b multi=%0b cnt=%0d, expected idx=%0d none=%0b multi=%0b cnt=%0d",
                     inst, act[2:0], act[3], act[4], act[12:5], e[2:0], e[3], e[4], e[12:5]);
        end
    endtask

    // Monitor: a result is consumed on the edge following a negedge where
    // out_valid && out_ready; compare it against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_v[0] && out_ready) check_pop(0, {cnt0, multi_v[0], none_v[0], idx0});
            if (out_valid_v[1] && out_ready) check_pop(1, {cnt1, multi_v[1], none_v[1], idx1});
            if (out_valid_v[2] && out_ready) check_pop(2, {6'b0, cnt2, multi_v[2], none_v[2], idx2});
        end
    end

    // Called at posedge+1; presents a vector to one instance and waits one edge.
    task automatic send(input int inst, input logic [7:0] vec, input logic [2:0] e_idx,
                        input logic e_none, input logic e_multi, input logic [7:0] e_cnt);
        in_bus     = vec;
        in_valid_v = 3'b001 << inst;
        case (inst)
            0: exp0_q.push_back(pack(e_idx, e_none, e_multi, e_cnt));
            1: exp1_q.push_back(pack(e_idx, e_none, e_multi, e_cnt));
            default: exp2_q.push_back(pack(e_idx, e_none, e_multi, e_cnt));
        endcase
        @(posedge clk);
        #1;
        chk($sformatf("latency_valid[%0d]", inst), {31'b0, out_valid_v[inst]}, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid_v = 3'b000;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_bus     = 8'h00;
        in_valid_v = 3'b000;
        out_ready  = 1'b1;
        #12;
        chk("reset_in_ready",  {29'b0, in_ready_v},  32'h7);
        chk("reset_out_valid", {29'b0, out_valid_v}, 32'h0);
        chk("reset_cnt0",      {24'b0, cnt0},        32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Test 1: one-hot walk, fixed priority
        for (int i = 0; i < 8; i++) begin
            send(0, 8'h01 << i, 3'(i), 1'b0, 1'b0, 8'd0);
        end
        // Test 2: malformed vectors
        send(0, 8'h00, 3'd0, 1'b1, 1'b0, 8'd1);
        send(0, 8'h0C, 3'd2, 1'b0, 1'b1, 8'd2);

        // Test 4: stall on the 0x0C result while a new vector waits
        out_ready = 1'b0;
        in_bus    = 8'h30;
        #1;
        chk("stall_in_ready0", {31'b0, in_ready_v[0]}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", {31'b0, in_ready_v[0]},  32'd0);
            chk("stall_valid",    {31'b0, out_valid_v[0]}, 32'd1);
            chk("stall_idx",      {29'b0, idx0},           32'd2);
            chk("stall_flags",    {30'b0, multi_v[0], none_v[0]}, 32'b10);
            chk("stall_cnt",      {24'b0, cnt0},           32'd2);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'b0, in_ready_v[0]}, 32'd1);
        exp0_q.push_back(pack(3'd4, 1'b0, 1'b1, 8'd3));
        @(posedge clk);
        #1;
        idle(3);

        // Test 3: round-robin on 0x81, pointer wrapping
        send(1, 8'h81, 3'd0, 1'b0, 1'b1, 8'd1);
        send(1, 8'h81, 3'd7, 1'b0, 1'b1, 8'd2);
        send(1, 8'h81, 3'd0, 1'b0, 1'b1, 8'd3);
        send(1, 8'h81, 3'd7, 1'b0, 1'b1, 8'd4);
        send(1, 8'h06, 3'd1, 1'b0, 1'b1, 8'd5);
        out_ready = 1'b0;
        in_bus    = 8'h81;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("rr_stall_in_ready", {31'b0, in_ready_v[1]}, 32'd0);
            chk("rr_stall_idx",      {29'b0, idx1},          32'd1);
            chk("rr_stall_cnt",      {24'b0, cnt1},          32'd5);
        end

        // Test 5: asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid",    {31'b0, out_valid_v[1]}, 32'd0);
        chk("arst_idx",      {29'b0, idx1},           32'd0);
        chk("arst_flags",    {30'b0, multi_v[1], none_v[1]}, 32'd0);
        chk("arst_cnt",      {24'b0, cnt1},           32'd0);
        chk("arst_in_ready", {31'b0, in_ready_v[1]},  32'd1);
        exp1_q.delete();
        in_valid_v = 3'b000;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        // pointer restarts at 0; all-zero leaves it alone
        send(1, 8'h81, 3'd0, 1'b0, 1'b1, 8'd1);
        send(1, 8'h00, 3'd0, 1'b1, 1'b0, 8'd2);
        send(1, 8'h81, 3'd7, 1'b0, 1'b1, 8'd3);
        idle(3);

        // Test 6: N=5, counter saturation and modulo-5 wrap
        send(2, 8'h10, 3'd4, 1'b0, 1'b0, 8'd0);
        send(2, 8'h00, 3'd0, 1'b1, 1'b0, 8'd1);
        send(2, 8'h00, 3'd0, 1'b1, 1'b0, 8'd2);
        for (int i = 0; i < 4; i++) begin
            send(2, 8'h00, 3'd0, 1'b1, 1'b0, 8'd3);
        end
        send(2, 8'h01, 3'd0, 1'b0, 1'b0, 8'd3);
        send(2, 8'h0A, 3'd1, 1'b0, 1'b1, 8'd3);
        send(2, 8'h11, 3'd4, 1'b0, 1'b1, 8'd3);
        send(2, 8'h11, 3'd0, 1'b0, 1'b1, 8'd3);
        idle(3);

        chk("drain_q0", exp0_q.size(), 32'd0);
        chk("drain_q1", exp1_q.size(), 32'd0);
        chk("drain_q2", exp2_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
